// File: rtl/regfile_dump_reader_if.sv
// Bundle between the dump reader, the register file read port and the trace consumer.
// With DUMP_CHECKSUM_EN defined, the bundle also carries the running checksum.
interface regfile_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] first_reg;
  logic [ADDR_W-1:0] last_reg;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  // out_* handshake: a word moves on a rising edge where out_valid & out_ready;
  // while out_valid is high and out_ready low, out_data/out_index/out_last hold still.
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;
  logic              busy;
  logic              done;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  modport master (
    output start, first_reg, last_reg, rd_data, out_ready,
    input  rd_addr, out_valid, out_data, out_index, out_last, busy, done
`ifdef DUMP_CHECKSUM_EN
    , input checksum
`endif
  );

  modport slave (
    input  start, first_reg, last_reg, rd_data, out_ready,
    output rd_addr, out_valid, out_data, out_index, out_last, busy, done
`ifdef DUMP_CHECKSUM_EN
    , output checksum
`endif
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks a wrap-around range of register indices through one read port and streams each word out.
// Optional running checksum of streamed words: define DUMP_CHECKSUM_EN.
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_dump_reader_if.slave   bus,
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic              out_last_q, out_last_d;
  logic [ADDR_W-1:0] cur_next;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;
`endif

  // Explicit wrap keeps the walk correct even if NUM_REGS is not a power of two.
  assign cur_next = (cur_q == ADDR_W'(NUM_REGS - 1)) ? '0 : cur_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    end_d       = end_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
`ifdef DUMP_CHECKSUM_EN
    checksum_d  = checksum_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cur_d   = bus.first_reg;
          end_d   = bus.last_reg;
          state_d = READ;
`ifdef DUMP_CHECKSUM_EN
          checksum_d = '0;
`endif
        end
      end
      READ: begin
        out_data_d  = bus.rd_data;
        out_index_d = cur_q;
        out_last_d  = (cur_q == end_q);
        state_d     = SEND;
      end
      SEND: begin
        if (bus.out_ready) begin
`ifdef DUMP_CHECKSUM_EN
          checksum_d = checksum_q + out_data_q;
`endif
          if (out_last_q) begin
            state_d = DONE;
          end else begin
            cur_d   = cur_next;
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      end_q       <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      end_q       <= end_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
`ifdef DUMP_CHECKSUM_EN
      checksum_q  <= checksum_d;
`endif
    end
  end

  // Valid is exactly the SEND state, so it drops on the handshake edge without a separate flop.
  assign bus.rd_addr   = cur_q;
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
`ifdef DUMP_CHECKSUM_EN
  assign bus.checksum  = checksum_q;
`endif
  assign dbg_state_o   = state_q;

endmodule
